// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment codes and decode helper
// Exports: SEG_0..SEG_9, SEG_BLANK (active-low {a,b,c,d,e,f,g}),
//          NIBBLE_BLANK, NIBBLE_ILLEGAL, seg_dec_t, seg_to_bcd().
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIBBLE_BLANK   = 4'hF;
  localparam logic [3:0] NIBBLE_ILLEGAL = 4'hE;

  typedef struct packed {
    logic       blank;
    logic       illegal;
    logic [3:0] nibble;
  } seg_dec_t;

  function automatic seg_dec_t seg_to_bcd(input logic [6:0] seg);
    seg_dec_t d;
    d.blank   = 1'b0;
    d.illegal = 1'b0;
    d.nibble  = NIBBLE_ILLEGAL;
    case (seg)
      SEG_0:     d.nibble = 4'd0;
      SEG_1:     d.nibble = 4'd1;
      SEG_2:     d.nibble = 4'd2;
      SEG_3:     d.nibble = 4'd3;
      SEG_4:     d.nibble = 4'd4;
      SEG_5:     d.nibble = 4'd5;
      SEG_6:     d.nibble = 4'd6;
      SEG_7:     d.nibble = 4'd7;
      SEG_8:     d.nibble = 4'd8;
      SEG_9:     d.nibble = 4'd9;
      SEG_BLANK: begin
        d.blank  = 1'b1;
        d.nibble = NIBBLE_BLANK;
      end
      default:   d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sevenseg_stable_filter.sv
// rtl/sevenseg_stable_filter.sv - synchronizer, run-length counter and accept strobe
// Ports: clk, rst_n (async active-low), din (asynchronous bus),
//        sample (synchronized bus), accept (one strobe per stable period).
module sevenseg_stable_filter #(
  parameter int W             = 11,
  parameter int STABLE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sample,
  output logic         accept
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Fires on the single edge where the counter steps into saturation, so a
  // long-held pattern is accepted exactly once until the bus changes again.
  assign accept = (sync2 == prev) && (cnt == CNT_PRE);
  assign sample = sync2;

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// rtl/sevenseg_scan_decoder.sv - multiplexed seven-segment bus to BCD frame monitor
// Ports: clk, rst_n (async active-low), seg_n[6:0], an_n[NUM_DIGITS-1:0], clr,
//        bcd_out, digit_blank, frame_valid (pulse), seg_err, an_err (sticky).
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    seg_err,
  output logic                    an_err
);

  logic [NUM_DIGITS+6:0]   sample;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_s;
  logic                    one_hot;
  logic                    multi;
  seg_dec_t                dec;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   next_mask;
  logic                    complete;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic [4*NUM_DIGITS-1:0] merged_bcd;
  logic [NUM_DIGITS-1:0]   merged_blank;

  sevenseg_stable_filter #(
    .W             (NUM_DIGITS + 7),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({an_n, seg_n}),
    .sample (sample),
    .accept (accept)
  );

  assign an_act = ~sample[NUM_DIGITS+6:7];
  assign seg_s  = sample[6:0];
  assign dec    = seg_to_bcd(seg_s);

  // x & (x-1) clears the lowest set bit; zero afterwards means one bit was set.
  assign one_hot   = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
  assign multi     = (an_act != '0) && !one_hot;
  assign next_mask = mask | an_act;
  assign complete  = (next_mask == '1);

  // Shadow contents with the digit being accepted spliced in, so a completing
  // accept publishes its own digit on the same edge.
  always_comb begin
    merged_bcd   = shadow_bcd;
    merged_blank = shadow_blank;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (an_act[k]) begin
        merged_bcd[4*k +: 4] = dec.nibble;
        merged_blank[k]      = dec.blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask         <= '0;
      shadow_bcd   <= '0;
      shadow_blank <= '0;
      bcd_out      <= '0;
      digit_blank  <= '0;
      frame_valid  <= 1'b0;
      seg_err      <= 1'b0;
      an_err       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (clr) begin
        // A coincident accept is intentionally dropped.
        mask    <= '0;
        seg_err <= 1'b0;
        an_err  <= 1'b0;
      end else if (accept) begin
        if (multi) begin
          an_err <= 1'b1;
        end else if (one_hot) begin
          shadow_bcd   <= merged_bcd;
          shadow_blank <= merged_blank;
          if (dec.illegal)
            seg_err <= 1'b1;
          if (complete) begin
            bcd_out     <= merged_bcd;
            digit_blank <= merged_blank;
            mask        <= '0;
            frame_valid <= 1'b1;
          end else begin
            mask <= next_mask;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// tb/tb_sevenseg_scan_decoder.sv - scoreboard bench for sevenseg_scan_decoder
module tb_sevenseg_scan_decoder;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S4   = 7'b1001100;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S6   = 7'b0100000;
  localparam logic [6:0] S7   = 7'b0001111;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0000100;
  localparam logic [6:0] SB   = 7'b1111111;
  localparam logic [6:0] SBAD = 7'b0110000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic        clr = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  digit_blank;
  logic        frame_valid;
  logic        seg_err;
  logic        an_err;

  int tests = 0;
  int fails = 0;
  int frame_cnt = 0;
  logic [15:0] exp_bcd_q[$];
  logic [3:0]  exp_blank_q[$];

  sevenseg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clr         (clr),
    .bcd_out     (bcd_out),
    .digit_blank (digit_blank),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .an_err      (an_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic show(input int k, input logic [6:0] seg, input int cyc);
    logic [3:0] a;
    a = 4'hF;
    a[k] = 1'b0;
    an_n = a;
    seg_n = seg;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic blank_bus(input int cyc);
    an_n = 4'hF;
    seg_n = SB;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [15:0] b, input logic [3:0] bl);
    exp_bcd_q.push_back(b);
    exp_blank_q.push_back(bl);
  endtask

  // Monitor: every frame_valid cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      frame_cnt++;
      if (exp_bcd_q.size() == 0) begin
        check("unexpected_frame", 32'(bcd_out), 32'hFFFF_FFFF);
      end else begin
        check("frame_bcd", 32'(bcd_out), 32'(exp_bcd_q.pop_front()));
        check("frame_blank", 32'(digit_blank), 32'(exp_blank_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    bit seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_bcd", 32'(bcd_out), 0);
    check("reset_blank", 32'(digit_blank), 0);
    check("reset_fv", 32'(frame_valid), 0);
    check("reset_errs", 32'({seg_err, an_err}), 0);
    rst_n = 1'b1;
    blank_bus(12);

    // Digit drive: 0x1947
    expect_frame(16'h1947, 4'b0000);
    show(3, S1, 20);
    show(2, S9, 20);
    show(1, S4, 20);
    show(0, S7, 20);
    blank_bus(5);
    check("t1_frames", frame_cnt, 1);
    check("t1_errs", 32'({seg_err, an_err}), 0);

    // Glitch filtering and accept latency
    expect_frame(16'h2835, 4'b0000);
    show(3, S2, 20);
    show(2, S8, 20);
    show(1, S3, 20);
    show(0, S5, 5);
    show(0, S6, 3);
    seg_n = S5;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (frame_valid) seen = 1;
    end
    check("t2_latency", n, 10);
    blank_bus(5);
    check("t2_frames", frame_cnt, 2);
    check("t2_bcd_digit0", 32'(bcd_out[3:0]), 5);

    // Illegal pattern and blank digit
    expect_frame(16'h0FE8, 4'b0100);
    show(3, S0, 20);
    show(2, SB, 20);
    show(1, SBAD, 20);
    show(0, S8, 20);
    blank_bus(5);
    check("t3_frames", frame_cnt, 3);
    check("t3_seg_err", 32'(seg_err), 1);
    expect_frame(16'h1234, 4'b0000);
    show(3, S1, 20);
    show(2, S2, 20);
    show(1, S3, 20);
    show(0, S4, 20);
    blank_bus(5);
    check("t3_seg_err_sticky", 32'(seg_err), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("t3_seg_err_clr", 32'(seg_err), 0);
    check("t3_bcd_retained", 32'(bcd_out), 32'h1234);

    // Anode error, then clr racing an accept
    base = frame_cnt;
    show(3, S5, 20);
    show(2, S6, 20);
    an_n = 4'b1100;
    seg_n = S3;
    repeat (20) @(negedge clk);
    check("t4_an_err", 32'(an_err), 1);
    check("t4_no_frame_err", frame_cnt - base, 0);
    show(1, S7, 20);
    check("t4_no_frame_d1", frame_cnt - base, 0);
    an_n = 4'b1110;
    seg_n = S8;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_an_err_clr", 32'(an_err), 0);
    check("t4_accept_dropped", frame_cnt - base, 0);
    expect_frame(16'h4209, 4'b0000);
    show(0, S9, 20);
    show(1, S0, 20);
    show(2, S2, 20);
    check("t4_mask_cleared", frame_cnt - base, 0);
    show(3, S4, 20);
    blank_bus(5);
    check("t4_frames", frame_cnt - base, 1);

    // Reset mid-frame
    base = frame_cnt;
    show(0, S3, 20);
    show(1, SBAD, 20);
    check("t5_seg_err_pre", 32'(seg_err), 1);
    blank_bus(5);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_bcd", 32'(bcd_out), 0);
    check("t5_rst_blank", 32'(digit_blank), 0);
    check("t5_rst_errs", 32'({seg_err, an_err, frame_valid}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    blank_bus(12);
    expect_frame(16'h0000, 4'b0000);
    show(3, S0, 20);
    show(2, S0, 20);
    check("t5_partial_discarded", frame_cnt - base, 0);
    show(1, S0, 20);
    show(0, S0, 20);
    blank_bus(5);
    check("t5_frames", frame_cnt - base, 1);

    // Long blanking intervals between digits
    base = frame_cnt;
    expect_frame(16'h3141, 4'b0000);
    show(3, S3, 20);
    blank_bus(50);
    show(2, S1, 20);
    blank_bus(50);
    check("t6_mid_bcd", 32'(bcd_out), 0);
    check("t6_mid_frames", frame_cnt - base, 0);
    show(1, S4, 20);
    blank_bus(50);
    show(0, S1, 20);
    blank_bus(5);
    check("t6_frames", frame_cnt - base, 1);
    check("t6_errs", 32'({seg_err, an_err}), 0);

    check("scoreboard_empty", exp_bcd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
